// File: rtl/jk_bank_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// jk_bank_sched
//
// Shared-bank scheduler for a bank of JK cells. Several requesters each post one
// JK command (HOLD/SET/RESET/TOGGLE) aimed at one cell; the scheduler grants one
// requester at a time, applies its command, then acknowledges it.
//
// Build option:
//   JKSCHED_RR_EN  defined   -> round-robin arbitration (pointer starts at NREQ-1)
//                  undefined -> fixed priority, lowest requester index wins
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-low reset
//   req   in   [NREQ]        request per requester, held until its ack
//   cmd   in   [2*NREQ]      {j,k} per requester: 00 HOLD, 01 SET, 10 RESET, 11 TOGGLE
//   addr  in   [ABITS*NREQ]  target cell per requester
//   ack   out  [NREQ]        one-hot, one-cycle acknowledge to the granted requester
//   err   out                pulses with ack when the granted address is >= NBITS
//   busy  out                high while a command is in flight
//   q     out  [NBITS]       cell states
//   qb    out  [NBITS]       inverse of q
//
// Cycle view (t0 = sampling edge): q changes at t1, ack/err high t2..t3,
// busy high t0..t3, next sample possible at t3.
// -----------------------------------------------------------------------------
module jk_bank_sched #(
  parameter int NREQ  = 4,
  parameter int NBITS = 6,
  parameter int ABITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       cmd,
  input  logic [ABITS*NREQ-1:0]   addr,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic                    busy,
  output logic [NBITS-1:0]        q,
  output logic [NBITS-1:0]        qb
);

  // state | meaning
  // ------+---------------------------------------------------------------
  // IDLE  | waiting; samples req/cmd/addr and latches the winner
  // EXEC  | applies the latched command to the addressed cell (or flags err)
  // ACK   | loads the one-cycle ack/err pulse for the winner
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    win_l;
  logic [1:0]       cmd_l;
  logic [ABITS-1:0] addr_l;
  logic             err_l;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef JKSCHED_RR_EN
  logic [IW-1:0] rr_ptr;

  // Search order starts one past the last grant and wraps.
  always_comb begin
    int c;
    win_vld = 1'b0;
    win_idx = '0;
    c       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!win_vld && req[c]) begin
        win_vld = 1'b1;
        win_idx = IW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= IW'(NREQ - 1);
    end else if (state == S_IDLE && win_vld) begin
      rr_ptr <= win_idx;
    end
  end
`else
  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  function automatic logic jk_next(input logic [1:0] c, input logic cur);
    case (c)
      2'b01:   jk_next = 1'b1;
      2'b10:   jk_next = 1'b0;
      2'b11:   jk_next = ~cur;
      default: jk_next = cur;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      win_l  <= '0;
      cmd_l  <= '0;
      addr_l <= '0;
      err_l  <= 1'b0;
      q      <= '0;
      ack    <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_nxt;
      // The ack cycle follows ACK, so busy is stretched across it.
      busy  <= (state_nxt != S_IDLE) || (state == S_ACK);
      ack   <= '0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            win_l  <= win_idx;
            cmd_l  <= cmd[2*int'(win_idx) +: 2];
            addr_l <= addr[ABITS*int'(win_idx) +: ABITS];
            err_l  <= 1'b0;
          end
        end
        S_EXEC: begin
          if (int'(addr_l) >= NBITS) begin
            err_l <= 1'b1;
          end else begin
            for (int b = 0; b < NBITS; b++) begin
              if (int'(addr_l) == b) q[b] <= jk_next(cmd_l, q[b]);
            end
          end
        end
        S_ACK: begin
          ack[win_l] <= 1'b1;
          err        <= err_l;
        end
        default: ;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_jk_bank_sched.sv
`timescale 1ns/1ps
module tb_jk_bank_sched;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int ABITS = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     cmd;
  logic [ABITS*NREQ-1:0] addr;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [NBITS-1:0]      q;
  logic [NBITS-1:0]      qb;

  jk_bank_sched #(.NREQ(NREQ), .NBITS(NBITS), .ABITS(ABITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .addr (addr),
    .ack  (ack),
    .err  (err),
    .busy (busy),
    .q    (q),
    .qb   (qb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [NREQ-1:0]  ack;
    logic             err;
    logic [NBITS-1:0] q;
  } exp_t;

  exp_t sb_q[$];

  int mon_checks  = 0;
  int mon_errors  = 0;
  int stim_checks = 0;
  int stim_errors = 0;

  // Monitor: every ack/err pulse is matched against the next expected entry.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst === 1'b1 && (ack !== '0 || err !== 1'b0)) begin
      mon_checks++;
      if (sb_q.size() == 0) begin
        mon_errors++;
        $display("FAIL unexpected_ack: got ack=%b err=%b q=%b, expected no ack", ack, err, q);
      end else begin
        e = sb_q.pop_front();
        if (ack !== e.ack || err !== e.err || q !== e.q || qb !== ~e.q) begin
          mon_errors++;
          $display("FAIL sb_ack: got ack=%b err=%b q=%b qb=%b, expected ack=%b err=%b q=%b qb=%b",
                   ack, err, q, qb, e.ack, e.err, e.q, ~e.q);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    stim_checks++;
    if (act !== expv) begin
      stim_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] a, input logic e, input logic [NBITS-1:0] qq);
    exp_t x;
    x.ack = a;
    x.err = e;
    x.q   = qq;
    sb_q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [ABITS-1:0] a);
    cmd[2*i +: 2]         = c;
    addr[ABITS*i +: ABITS] = a;
    req[i]                = 1'b1;
  endtask

  // Returns cycles from the drive point until ack[i] is seen, or -1 on timeout.
  task automatic wait_ack(input int i, input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (ack[i] === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      stim_checks++;
      stim_errors++;
      $display("FAIL ack_timeout: req%0d got no ack within %0d cycles", i, budget);
    end
  endtask

  // Waits for any ack pulse and drops the acked request bits unless told to keep them.
  task automatic wait_any_ack(input int budget, input logic drop);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack === '0 && n < budget);
    if (ack === '0) begin
      stim_checks++;
      stim_errors++;
      $display("FAIL any_ack_timeout: got no ack within %0d cycles", budget);
    end else if (drop) begin
      req = req & ~ack;
    end
  endtask

  task automatic issue_one(input string name, input int i, input logic [1:0] c,
                           input logic [ABITS-1:0] a, input logic e,
                           input logic [NBITS-1:0] qq);
    int lat;
    @(posedge clk);
    #1;
    push(NREQ'(1) << i, e, qq);
    set_req(i, c, a);
    wait_ack(i, 10, lat);
    check(name, lat, 3);
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    req = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_q", q, 6'b000000);
    check("rst_qb", qb, 6'b111111);
    check("rst_ack", ack, 4'b0000);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t_start;
    int lat;
    logic [1:0]       vec_cmd [5];
    logic [NBITS-1:0] vec_q   [5];

    req  = '0;
    cmd  = '0;
    addr = '0;

    // Reset values
    do_reset();

    // Contention: every requester SETs its own cell, each drops after its ack.
    push(4'b0001, 1'b0, 6'b000001);
    push(4'b0010, 1'b0, 6'b000011);
    push(4'b0100, 1'b0, 6'b000111);
    push(4'b1000, 1'b0, 6'b001111);
    t_start = cyc;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, ABITS'(i));
    for (int k = 0; k < NREQ; k++) wait_any_ack(20, 1'b1);
    check("contention_span", cyc - t_start, 12);
    check("contention_q", q, 6'b001111);

    // Reset in the middle of EXEC of a SET to cell 2.
    @(posedge clk);
    #1;
    set_req(0, 2'b01, 3'd2);
    @(posedge clk);
    #1;
    check("midexec_busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    req = '0;
    #1;
    check("midrst_q", q, 6'b000000);
    check("midrst_qb", qb, 6'b111111);
    check("midrst_ack", ack, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_q", q, 6'b000000);
    check("postrst_busy", busy, 1'b0);

    // Single requester sequence on cell 3.
    vec_cmd = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    vec_q   = '{6'b001000, 6'b000000, 6'b001000, 6'b000000, 6'b000000};
    for (int v = 0; v < 5; v++) issue_one("single_lat", 0, vec_cmd[v], 3'd3, 1'b0, vec_q[v]);

`ifdef JKSCHED_RR_EN
    // Fairness: req1 and req3 both held; grants alternate 1,3,1,3.
    do_reset();
    push(4'b0010, 1'b0, 6'b000010);
    push(4'b1000, 1'b0, 6'b001010);
    push(4'b0010, 1'b0, 6'b001000);
    push(4'b1000, 1'b0, 6'b000000);
    @(posedge clk);
    #1;
    set_req(1, 2'b11, 3'd1);
    set_req(3, 2'b11, 3'd3);
    for (int k = 0; k < 3; k++) wait_any_ack(20, 1'b0);
    wait_any_ack(20, 1'b0);
    req = '0;
    repeat (5) @(posedge clk);
    #1;
    check("fair_q", q, 6'b000000);
`else
    // Fixed priority: req0 held continuously starves req1.
    do_reset();
    for (int k = 0; k < 4; k++) push(4'b0001, 1'b0, 6'b000001);
    push(4'b0010, 1'b0, 6'b000011);
    @(posedge clk);
    #1;
    set_req(0, 2'b01, 3'd0);
    set_req(1, 2'b01, 3'd1);
    for (int k = 0; k < 4; k++) wait_any_ack(20, 1'b0);
    req[0] = 1'b0;
    wait_ack(1, 10, lat);
    check("starve_release_lat", lat, 3);
    req[1] = 1'b0;
`endif

    // Out-of-range addresses leave q alone and raise err with the ack.
    do_reset();
    issue_one("setup_lat", 1, 2'b01, 3'd5, 1'b0, 6'b100000);
    issue_one("oor7_lat", 2, 2'b11, 3'd7, 1'b1, 6'b100000);
    issue_one("oor6_lat", 2, 2'b01, 3'd6, 1'b1, 6'b100000);

    // Late change: cmd/req altered during EXEC are ignored.
    issue_one("pre_late_lat", 0, 2'b01, 3'd0, 1'b0, 6'b100001);
    @(posedge clk);
    #1;
    push(4'b0001, 1'b0, 6'b100000);
    set_req(0, 2'b11, 3'd0);
    @(posedge clk);
    #1;
    cmd[1:0] = 2'b01;
    req[0]   = 1'b0;
    wait_ack(0, 10, lat);
    check("late_lat", lat, 2);
    repeat (5) @(posedge clk);
    #1;
    check("late_q", q, 6'b100000);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             mon_checks + stim_checks, mon_errors + stim_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000ns");
    $fatal(1);
  end

endmodule
